// File: rtl/dbus_arb_pkg.sv
// rtl/dbus_arb_pkg.sv - shared types and default widths for the data-bus arbiter
package dbus_arb_pkg;

    localparam int DEF_NCORES = 4;
    localparam int DEF_AW     = 32;
    localparam int DEF_DW     = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } arb_state_t;

    // Owner index width; a single core still gets a 1-bit index.
    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dbus_arbiter_if.sv
// rtl/dbus_arbiter_if.sv - core-side and memory-side bus bundle (lock_i present under DBUS_ARB_LOCK_EN)
interface dbus_arbiter_if
    import dbus_arb_pkg::*;
#(
    parameter int NCORES = DEF_NCORES,
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW
);
    localparam int OW = owner_width(NCORES);

    logic [NCORES-1:0]        req_i;
    logic [NCORES-1:0]        we_i;
    logic [NCORES*AW-1:0]     addr_i;
    logic [NCORES*DW-1:0]     wdata_i;
    logic [NCORES*DW/8-1:0]   wstrb_i;
    logic [NCORES-1:0]        ack_o;
    logic [DW-1:0]            rdata_o;
    logic [OW-1:0]            owner_o;
    logic                     mem_valid_o;
    logic                     mem_ready_i;
    logic                     mem_we_o;
    logic [AW-1:0]            mem_addr_o;
    logic [DW-1:0]            mem_wdata_o;
    logic [DW/8-1:0]          mem_wstrb_o;
    logic                     mem_rvalid_i;
    logic [DW-1:0]            mem_rdata_i;
`ifdef DBUS_ARB_LOCK_EN
    logic [NCORES-1:0]        lock_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, wstrb_i, lock_i,
        input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
        output ack_o, rdata_o, owner_o,
        output mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, wstrb_i, lock_i,
        output mem_ready_i, mem_rvalid_i, mem_rdata_i,
        input  ack_o, rdata_o, owner_o,
        input  mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
    );
`else
    modport slave (
        input  req_i, we_i, addr_i, wdata_i, wstrb_i,
        input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
        output ack_o, rdata_o, owner_o,
        output mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, wstrb_i,
        output mem_ready_i, mem_rvalid_i, mem_rdata_i,
        input  ack_o, rdata_o, owner_o,
        input  mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
    );
`endif

endinterface

// File: rtl/dbus_rr_picker.sv
// rtl/dbus_rr_picker.sv - combinational round-robin picker: first set request at or above ptr, wrapping
module dbus_rr_picker
    import dbus_arb_pkg::*;
#(
    parameter  int NCORES = DEF_NCORES,
    localparam int OW     = owner_width(NCORES)
) (
    input  logic [NCORES-1:0] req,
    input  logic [OW-1:0]     ptr,
    output logic              valid,
    output logic [OW-1:0]     idx
);
    localparam logic [OW:0] N_W = NCORES[OW:0];

    logic [NCORES-1:0] rot;
    logic [OW-1:0]     off;
    logic [OW:0]       sum;

    // Rotate so bit 0 is the pointer position, find the lowest set bit, then undo the rotation.
    always_comb begin
        rot = NCORES'({req, req} >> ptr);
        off = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = OW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        valid = |req;
        idx   = sum[OW-1:0];
    end

endmodule

// File: rtl/dbus_arbiter.sv
// rtl/dbus_arbiter.sv - round-robin data-bus arbiter, one outstanding transaction (optional lock: DBUS_ARB_LOCK_EN)
module dbus_arbiter
    import dbus_arb_pkg::*;
#(
    parameter int NCORES = DEF_NCORES,
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    dbus_arbiter_if.slave  bus
);
    localparam int OW = owner_width(NCORES);
    localparam int SW = DW / 8;

    arb_state_t        state;
    logic [OW-1:0]     ptr;
    logic [OW-1:0]     owner_q;
    logic [NCORES-1:0] ack_q;
    logic [DW-1:0]     rdata_q;
    logic              mem_valid_q;
    logic              mem_we_q;
    logic [AW-1:0]     mem_addr_q;
    logic [DW-1:0]     mem_wdata_q;
    logic [SW-1:0]     mem_wstrb_q;
`ifdef DBUS_ARB_LOCK_EN
    logic              lock_hold;
`endif

    logic              pick_valid;
    logic [OW-1:0]     pick_idx;
    logic              grant_valid;
    logic [OW-1:0]     grant_idx;
    logic [NCORES-1:0] owner_hot;
    logic [OW-1:0]     next_ptr;
    logic              ack_now;
    logic              sel_we;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_wdata;
    logic [SW-1:0]     sel_wstrb;

    dbus_rr_picker #(.NCORES(NCORES)) u_picker (
        .req   (bus.req_i),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        owner_hot = '0;
        for (int k = 0; k < NCORES; k++) begin
            owner_hot[k] = (owner_q == OW'(k));
        end
    end

    // A held lock re-grants the previous owner ahead of round-robin while it keeps requesting.
    always_comb begin
        grant_valid = pick_valid;
        grant_idx   = pick_idx;
`ifdef DBUS_ARB_LOCK_EN
        if (lock_hold && |(bus.req_i & owner_hot)) begin
            grant_valid = 1'b1;
            grant_idx   = owner_q;
        end
`endif
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int k = 0; k < NCORES; k++) begin
            if (grant_idx == OW'(k)) begin
                sel_we    = bus.we_i[k];
                sel_addr  = bus.addr_i[k*AW +: AW];
                sel_wdata = bus.wdata_i[k*DW +: DW];
                sel_wstrb = bus.wstrb_i[k*SW +: SW];
            end
        end
    end

    assign next_ptr = (owner_q == OW'(NCORES - 1)) ? '0 : owner_q + 1'b1;
    assign ack_now  = ((state == REQ)  && bus.mem_ready_i && mem_we_q) ||
                      ((state == RESP) && bus.mem_rvalid_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            ptr         <= '0;
            owner_q     <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
`ifdef DBUS_ARB_LOCK_EN
            lock_hold   <= 1'b0;
`endif
        end else begin
            ack_q <= '0;
            unique case (state)
                IDLE: begin
`ifdef DBUS_ARB_LOCK_EN
                    lock_hold <= 1'b0;
`endif
                    if (grant_valid) begin
                        owner_q     <= grant_idx;
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        mem_wstrb_q <= sel_wstrb;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_ready_i) begin
                        mem_valid_q <= 1'b0;
                        state       <= mem_we_q ? IDLE : RESP;
                    end
                end
                RESP: begin
                    if (bus.mem_rvalid_i) begin
                        rdata_q <= bus.mem_rdata_i;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (ack_now) begin
                ack_q <= owner_hot;
`ifdef DBUS_ARB_LOCK_EN
                if (|(bus.lock_i & owner_hot)) begin
                    lock_hold <= 1'b1;
                end else begin
                    ptr <= next_ptr;
                end
`else
                ptr <= next_ptr;
`endif
            end
        end
    end

    assign bus.ack_o       = ack_q;
    assign bus.rdata_o     = rdata_q;
    assign bus.owner_o     = owner_q;
    assign bus.mem_valid_o = mem_valid_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.mem_wstrb_o = mem_wstrb_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb/tb_dbus_arbiter.sv - directed scoreboard bench for dbus_arbiter (lock steps under DBUS_ARB_LOCK_EN)
module tb_dbus_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic [1:0]  owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_exp_t;

    typedef struct packed {
        logic [3:0]  ack;
        logic [31:0] rdata;
    } ack_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_exp_t mem_q[$];
    ack_exp_t ack_q[$];
    mem_exp_t me;
    ack_exp_t ae;

    always #5 clk = ~clk;

    dbus_arbiter_if #(.NCORES(N), .AW(AW), .DW(DW)) bus ();

    dbus_arbiter #(.NCORES(N), .AW(AW), .DW(DW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int k, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        bus.we_i[k]             = we;
        bus.addr_i[k*AW +: AW]  = a;
        bus.wdata_i[k*DW +: DW] = d;
        bus.wstrb_i[k*4 +: 4]   = s;
    endtask

    task automatic exp_mem(input int k, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        mem_q.push_back('{owner: 2'(k), we: we, addr: a, wdata: d, wstrb: s});
    endtask

    task automatic exp_ack(input int k, input logic [31:0] rd);
        ack_q.push_back('{ack: 4'b0001 << k, rdata: rd});
    endtask

    task automatic wait_valid(input int max_cycles);
        int n = 0;
        while (!bus.mem_valid_o && n < max_cycles) begin
            tick();
            n++;
        end
        chk("wait_mem_valid", 64'(bus.mem_valid_o), 64'd1);
    endtask

    // Scoreboard: every memory handshake and every ack must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_valid_o && bus.mem_ready_i) begin
                checks++;
                assert (mem_q.size() > 0) else begin
                    errors++;
                    $error("FAIL mem_unexpected observed=addr 0x%0h expected=no request", bus.mem_addr_o);
                end
                if (mem_q.size() > 0) begin
                    me = mem_q.pop_front();
                    chk("sb_owner", 64'(bus.owner_o),     64'(me.owner));
                    chk("sb_we",    64'(bus.mem_we_o),    64'(me.we));
                    chk("sb_addr",  64'(bus.mem_addr_o),  64'(me.addr));
                    chk("sb_wdata", 64'(bus.mem_wdata_o), 64'(me.wdata));
                    chk("sb_wstrb", 64'(bus.mem_wstrb_o), 64'(me.wstrb));
                end
            end
            if (bus.ack_o != '0) begin
                checks++;
                assert (ack_q.size() > 0) else begin
                    errors++;
                    $error("FAIL ack_unexpected observed=0x%0h expected=no ack", bus.ack_o);
                end
                if (ack_q.size() > 0) begin
                    ae = ack_q.pop_front();
                    chk("sb_ack",   64'(bus.ack_o),   64'(ae.ack));
                    chk("sb_rdata", 64'(bus.rdata_o), 64'(ae.rdata));
                end
            end
        end
    end

    initial begin
        int rr_order[5]   = '{0, 1, 2, 3, 0};
`ifdef DBUS_ARB_LOCK_EN
        int lock_order[7] = '{0, 1, 2, 3, 3, 3, 0};
        bus.lock_i = '0;
`endif
        bus.req_i = '0;  bus.we_i = '0;  bus.addr_i = '0;  bus.wdata_i = '0;  bus.wstrb_i = '0;
        bus.mem_ready_i = 1'b0;  bus.mem_rvalid_i = 1'b0;  bus.mem_rdata_i = '0;

        // Reset state
        tick(); tick();
        chk("rst_ack",   64'(bus.ack_o),       64'd0);
        chk("rst_valid", 64'(bus.mem_valid_o), 64'd0);
        chk("rst_we",    64'(bus.mem_we_o),    64'd0);
        chk("rst_addr",  64'(bus.mem_addr_o),  64'd0);
        chk("rst_wdata", 64'(bus.mem_wdata_o), 64'd0);
        chk("rst_wstrb", 64'(bus.mem_wstrb_o), 64'd0);
        chk("rst_rdata", 64'(bus.rdata_o),     64'd0);
        chk("rst_owner", 64'(bus.owner_o),     64'd0);
        rst_n = 1'b1;
        tick();

        // Single write from core 2, memory ready immediately
        set_core(2, 1'b1, 32'h8000_0000, 32'h41, 4'hF);
        exp_mem(2, 1'b1, 32'h8000_0000, 32'h41, 4'hF);
        exp_ack(2, 32'h0);
        bus.mem_ready_i = 1'b1;
        bus.req_i = 4'b0100;
        tick();
        chk("wr_valid_lat1", 64'(bus.mem_valid_o), 64'd1);
        chk("wr_owner",      64'(bus.owner_o),     64'd2);
        chk("wr_addr",       64'(bus.mem_addr_o),  64'h8000_0000);
        tick();
        chk("wr_ack",        64'(bus.ack_o),       64'b0100);
        chk("wr_valid_drop", 64'(bus.mem_valid_o), 64'd0);
        bus.req_i = '0;
        tick();
        chk("wr_ack_pulse",  64'(bus.ack_o),       64'd0);

        // Read from core 1: ready two cycles late, rvalid three cycles after the handshake
        bus.mem_ready_i = 1'b0;
        set_core(1, 1'b0, 32'h100, 32'h0, 4'h0);
        exp_mem(1, 1'b0, 32'h100, 32'h0, 4'h0);
        bus.req_i = 4'b0010;
        tick();
        chk("rd_valid",   64'(bus.mem_valid_o), 64'd1);
        chk("rd_owner",   64'(bus.owner_o),     64'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rd_hold_valid", 64'(bus.mem_valid_o), 64'd1);
            chk("rd_hold_addr",  64'(bus.mem_addr_o),  64'h100);
            chk("rd_hold_we",    64'(bus.mem_we_o),    64'd0);
        end
        bus.mem_ready_i = 1'b1;
        tick();
        bus.mem_ready_i = 1'b0;
        chk("rd_valid_drop", 64'(bus.mem_valid_o), 64'd0);
        tick();
        chk("rd_no_early_ack", 64'(bus.ack_o), 64'd0);
        tick();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hDEAD_BEEF;
        exp_ack(1, 32'hDEAD_BEEF);
        tick();
        chk("rd_ack",   64'(bus.ack_o),   64'b0010);
        chk("rd_rdata", 64'(bus.rdata_o), 64'hDEAD_BEEF);
        bus.mem_rvalid_i = 1'b0;
        bus.req_i = '0;
        tick();

        // Write then read from core 0; rdata only moves at the read ack
        bus.mem_ready_i = 1'b1;
        set_core(0, 1'b1, 32'h200, 32'h55, 4'h1);
        exp_mem(0, 1'b1, 32'h200, 32'h55, 4'h1);
        exp_ack(0, 32'hDEAD_BEEF);
        bus.req_i = 4'b0001;
        tick();
        tick();
        chk("wtr_wr_ack",     64'(bus.ack_o),   64'b0001);
        chk("wtr_rdata_kept", 64'(bus.rdata_o), 64'hDEAD_BEEF);
        set_core(0, 1'b0, 32'h204, 32'h55, 4'h1);
        exp_mem(0, 1'b0, 32'h204, 32'h55, 4'h1);
        tick();
        chk("wtr_regrant", 64'(bus.mem_valid_o), 64'd1);
        tick();
        bus.mem_ready_i = 1'b0;
        chk("wtr_rdata_pending", 64'(bus.rdata_o), 64'hDEAD_BEEF);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h1234_5678;
        exp_ack(0, 32'h1234_5678);
        tick();
        chk("wtr_rd_ack",   64'(bus.ack_o),   64'b0001);
        chk("wtr_rd_rdata", 64'(bus.rdata_o), 64'h1234_5678);
        bus.mem_rvalid_i = 1'b0;
        bus.req_i = '0;
        tick();

        // Round-robin from reset with all cores requesting writes
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) set_core(k, 1'b1, 32'h1000 + 32'(k * 4), 32'hA0 + 32'(k), 4'hF);
        for (int n = 0; n < 5; n++) begin
            exp_mem(rr_order[n], 1'b1, 32'h1000 + 32'(rr_order[n] * 4), 32'hA0 + 32'(rr_order[n]), 4'hF);
            exp_ack(rr_order[n], 32'h0);
        end
        bus.mem_ready_i = 1'b1;
        bus.req_i = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_valid(8);
            chk("rr_owner", 64'(bus.owner_o), 64'(rr_order[n]));
            tick();
            chk("rr_ack", 64'(bus.ack_o), 64'(4'b0001 << rr_order[n]));
            if (n == 4) bus.req_i = '0;
        end
        tick();
        chk("rr_idle", 64'(bus.mem_valid_o), 64'd0);

        // Reset while a read is outstanding; next grant must restart from core 0
        set_core(2, 1'b0, 32'h300, 32'h0, 4'h0);
        exp_mem(2, 1'b0, 32'h300, 32'h0, 4'h0);
        bus.req_i = 4'b0100;
        tick();
        tick();
        bus.mem_ready_i = 1'b0;
        tick();
        rst_n = 1'b0;
        bus.req_i = '0;
        #1;
        chk("rstmid_valid", 64'(bus.mem_valid_o), 64'd0);
        chk("rstmid_ack",   64'(bus.ack_o),       64'd0);
        chk("rstmid_owner", 64'(bus.owner_o),     64'd0);
        tick(); tick();
        rst_n = 1'b1;
        exp_mem(0, 1'b1, 32'h1000, 32'hA0, 4'hF);
        exp_ack(0, 32'h0);
        bus.mem_ready_i = 1'b1;
        bus.req_i = 4'b0011;
        tick();
        chk("rstmid_grant", 64'(bus.owner_o), 64'd0);
        tick();
        chk("rstmid_ack0", 64'(bus.ack_o), 64'b0001);
        bus.req_i = '0;
        tick();

`ifdef DBUS_ARB_LOCK_EN
        // Lock: core 3 keeps the bus until lock_i drops
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 7; n++) begin
            exp_mem(lock_order[n], 1'b1, 32'h1000 + 32'(lock_order[n] * 4), 32'hA0 + 32'(lock_order[n]), 4'hF);
            exp_ack(lock_order[n], 32'h0);
        end
        bus.lock_i = 4'b1000;
        bus.req_i  = 4'b1111;
        for (int n = 0; n < 7; n++) begin
            wait_valid(8);
            chk("lock_owner", 64'(bus.owner_o), 64'(lock_order[n]));
            if (n == 5) bus.lock_i = '0;
            tick();
            chk("lock_ack", 64'(bus.ack_o), 64'(4'b0001 << lock_order[n]));
            if (n == 6) bus.req_i = '0;
        end
        tick();
`endif

        tick(); tick();
        chk("sb_mem_drained", 64'(mem_q.size()), 64'd0);
        chk("sb_ack_drained", 64'(ack_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=still running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the single data-bus port of the shared memory/MMIO subsystem among NCORES cores in `main`.
- Each core's dbus request (addr/we/wdata/wstrb) is arbitrated round-robin.
- One transaction is outstanding at a time. It is forwarded on a valid/ready memory port, and the completion (ack + read data) is routed back to the owning core.
- Cores stall on their own request until their ack pulses.

Parameters:
- NCORES, 4, number of requesting cores (1..8)
- AW, 32, address width
- DW, 32, data width; strobe width is DW/8

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NCORES  per-core request; held with fields stable until ack_o[k]
- we_i  in  NCORES  per-core write enable (1 = write)
- addr_i  in  NCORES*AW  per-core address, core k at [k*AW +: AW]
- wdata_i  in  NCORES*DW  per-core write data
- wstrb_i  in  NCORES*DW/8  per-core byte strobes
- ack_o  out  NCORES  one-hot, 1-cycle completion pulse
- rdata_o  out  DW  read data, valid in the ack cycle, shared by all cores
- owner_o  out  $clog2(NCORES) (min 1)  current/last owner index
- mem_valid_o  out  1  memory request valid
- mem_ready_i  in  1  memory accepts the request
- mem_we_o  out  1  forwarded write enable
- mem_addr_o  out  AW  forwarded address
- mem_wdata_o  out  DW  forwarded write data
- mem_wstrb_o  out  DW/8  forwarded strobes
- mem_rvalid_i  in  1  read response valid
- mem_rdata_i  in  DW  read response data

Behaviour:
- Reset (async, rst_ni=0) drives the following:
  - state = IDLE, rr pointer = 0, owner_o = 0.
  - ack_o = 0, mem_valid_o = 0, mem_we_o = 0.
  - mem_addr_o, mem_wdata_o, mem_wstrb_o and rdata_o = 0.
- Reset mid-transaction abandons it; no ack is issued. The memory side shares the reset.
- FSM states: IDLE, REQ, RESP.
- IDLE, when any req_i is set:
  - Pick the first set bit scanning from pointer upward, wrapping modulo NCORES.
  - Register the winner's fields onto mem_* and set mem_valid_o=1 next cycle.
  - owner_o = winner; go to REQ.
  - Request-to-mem_valid latency is 1 cycle.
- REQ:
  - mem_valid_o and all mem_* fields are held stable until mem_ready_i.
  - On handshake with mem_we_o=1: ack_o[owner]=1 next cycle, mem_valid_o=0, go to IDLE.
  - On handshake with mem_we_o=0: mem_valid_o=0, go to RESP.
- RESP:
  - On mem_rvalid_i, register mem_rdata_i into rdata_o and pulse ack_o[owner] next cycle; go to IDLE.
  - mem_rvalid_i is ignored outside RESP.
  - The memory never returns rvalid in the handshake cycle.
- Pointer update: pointer = (owner+1) mod NCORES whenever an ack is issued.
- The ack cycle is spent in IDLE, so arbitration resumes there. A core seeing ack_o[k] may hold req_i[k] high to request again; it competes under the updated pointer.
- Fairness: a continuously requesting core waits at most NCORES-1 transactions.
- rdata_o holds its value until the next read completes. Write acks leave rdata_o unchanged.
- req_i[owner] dropped before ack is a protocol violation. The transaction still completes and the ack is still pulsed.
- NCORES=1: the pointer stays 0 and the block degenerates to a 1-cycle register stage plus FSM.

Optional Feature:
- Macro: DBUS_ARB_LOCK_EN.
- When defined, add port lock_i (in, NCORES) and use it for atomic sequences (e.g. LR/SC, console multi-byte writes).
- At ack, if lock_i[owner]=1, the pointer is not advanced. The next IDLE arbitration grants owner unconditionally if req_i[owner]=1.
- If req_i[owner]=0 in that IDLE cycle, the lock is released and normal round-robin applies.
- When undefined, the lock_i port is absent and arbitration is pure round-robin.

Decomposition:
- Package dbus_arb_pkg holds the state enum (IDLE/REQ/RESP) and the default widths.
- Sub-module dbus_rr_picker: combinational round-robin picker taking (req vector, pointer) and producing (valid, index). It is instantiated once.

Test Plan:
- Single write: core 2 req, we=1, addr=0x80000000, wdata=0x41, mem_ready_i=1 at first valid. Expect:
  - mem_valid_o 1 cycle after req with the same fields.
  - ack_o=4'b0100 one cycle after the handshake.
- Read with latency: core 1 read of addr 0x100, mem_ready_i delayed 2 cycles, rvalid 3 cycles after the handshake with rdata=0xDEADBEEF. Expect:
  - mem_* fields stable through the delay.
  - ack_o=4'b0010 with rdata_o=0xDEADBEEF.
- Round-robin: all 4 cores request continuously from reset. Expect grant order 0,1,2,3,0 and no core granted twice before the others.
- Reset mid-RESP: assert rst_ni=0 while a read is outstanding. Expect immediately mem_valid_o=0, ack_o=0, owner_o=0; after release, the next grant goes to core 0.
- Lock (DBUS_ARB_LOCK_EN): core 3 with lock_i=1 plus all cores requesting. Expect core 3 granted repeatedly; after lock_i drops, the next grant is core 0.
- Write-then-read from the same core: rdata_o is unchanged after the write ack and updated only at the read ack.
